// File: rtl/ast_store_forward_fifo_pkg.sv
// Shared types and sizes for the store-and-forward Avalon-ST packet FIFO.
package ast_store_forward_fifo_pkg;

  localparam int DATA_OUT_W  = 128;
  localparam int EMPTY_OUT_W = 4;
  localparam int CHANNEL_W   = 10;
  localparam int SF_DEPTH    = 16;

  // One stored beat: payload plus its sideband, framing bits last.
  typedef struct packed {
    logic [DATA_OUT_W-1:0]  data;
    logic [EMPTY_OUT_W-1:0] empty;
    logic [CHANNEL_W-1:0]   channel;
    logic                   sop;
    logic                   eop;
  } sf_word_t;

  localparam int SF_WORD_W = $bits(sf_word_t);

endpackage

// File: rtl/ast_sf_ram.sv
// Simple dual-port storage with a registered read port; the array is not reset.
module ast_sf_ram
  import ast_store_forward_fifo_pkg::*;
#(
  parameter int WIDTH = SF_WORD_W,
  parameter int DEPTH = SF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // write port
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // read port, holds its last word when not enabled
  always_ff @(posedge clk_i) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ast_store_forward_fifo.sv
// Store-and-forward packet FIFO: a packet is released only once its EOP is
// stored, unless the head packet fills the whole store (cut-through escape).
// Optional macro AST_SF_LEVEL_EN adds usedw_o / pkt_cnt_o level outputs.
// A word keeps its storage slot until it leaves the output register, so
// `used` covers words in the read pipeline as well.
module ast_store_forward_fifo
  import ast_store_forward_fifo_pkg::*;
#(
  parameter int DEPTH = SF_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [DATA_OUT_W-1:0]  ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_OUT_W-1:0] ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,
  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i
`ifdef AST_SF_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] usedw_o,
  output logic [$clog2(DEPTH):0] pkt_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, pf_ptr_q, pf_ptr_d;
  logic [CW-1:0] used_q, used_d, pkt_cnt_q, pkt_cnt_d;
  logic          cut_thru_q, cut_thru_d;
  logic          rdy_q, rdy_d;
  logic          ram_vld_q, ram_vld_d;
  logic          out_vld_q, out_vld_d;
  sf_word_t      out_q, out_d;

  sf_word_t      wr_word, ram_word;
  logic          wr_en, rd_en, out_ld, fetch, pkt_ok;
  logic [1:0]    inflight, inflight_eop;
  logic [CW-1:0] avail;

  ast_sf_ram #(.WIDTH(SF_WORD_W), .DEPTH(DEPTH)) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_word),
    .rd_en_i   (fetch),
    .rd_addr_i (pf_ptr_q),
    .rd_data_o (ram_word)
  );

  // handshakes, prefetch decision and next-state of all control registers
  always_comb begin
    wr_word.data    = ast_data_i;
    wr_word.empty   = ast_empty_i;
    wr_word.channel = ast_channel_i;
    wr_word.sop     = ast_startofpacket_i;
    wr_word.eop     = ast_endofpacket_i;

    wr_en  = ast_valid_i & rdy_q;
    rd_en  = out_vld_q & ast_ready_i;
    out_ld = ram_vld_q & (~out_vld_q | ast_ready_i);

    // words/EOPs already fetched but not yet consumed downstream
    inflight     = {1'b0, ram_vld_q} + {1'b0, out_vld_q};
    inflight_eop = {1'b0, ram_vld_q & ram_word.eop} + {1'b0, out_vld_q & out_q.eop};
    avail        = used_q - CW'(inflight);

    // a complete packet not yet fetched, or the oversize head packet whose
    // EOP has not been fetched yet
    pkt_ok = (pkt_cnt_q > CW'(inflight_eop)) | (cut_thru_q & (inflight_eop == 2'd0));
    fetch  = (~ram_vld_q | out_ld) & (avail != '0) & pkt_ok;

    used_d    = used_q + CW'(wr_en) - CW'(rd_en);
    pkt_cnt_d = pkt_cnt_q + CW'(wr_en & ast_endofpacket_i) - CW'(rd_en & out_q.eop);
    rdy_d     = (used_d != CW'(DEPTH));
    wr_ptr_d  = wr_ptr_q + AW'(wr_en);
    pf_ptr_d  = pf_ptr_q + AW'(fetch);

    cut_thru_d = cut_thru_q;
    if (rd_en & out_q.eop) cut_thru_d = 1'b0;
    else if ((used_q == CW'(DEPTH)) && (pkt_cnt_q == '0)) cut_thru_d = 1'b1;

    ram_vld_d = fetch | (ram_vld_q & ~out_ld);
    out_vld_d = out_ld | (out_vld_q & ~ast_ready_i);
    out_d     = out_ld ? ram_word : out_q;
  end

  // control and output-stage registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      pf_ptr_q   <= '0;
      used_q     <= '0;
      pkt_cnt_q  <= '0;
      cut_thru_q <= 1'b0;
      rdy_q      <= 1'b0;
      ram_vld_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      pf_ptr_q   <= pf_ptr_d;
      used_q     <= used_d;
      pkt_cnt_q  <= pkt_cnt_d;
      cut_thru_q <= cut_thru_d;
      rdy_q      <= rdy_d;
      ram_vld_q  <= ram_vld_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
    end
  end

  assign ast_ready_o         = rdy_q;
  assign ast_valid_o         = out_vld_q;
  assign ast_data_o          = out_q.data;
  assign ast_empty_o         = out_q.empty;
  assign ast_channel_o       = out_q.channel;
  assign ast_startofpacket_o = out_q.sop;
  assign ast_endofpacket_o   = out_q.eop;

`ifdef AST_SF_LEVEL_EN
  assign usedw_o   = used_q;
  assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_ast_store_forward_fifo.sv
// Directed bench for the store-and-forward FIFO with a word scoreboard.
module tb_ast_store_forward_fifo;
  import ast_store_forward_fifo_pkg::*;

  localparam int CW = $clog2(SF_DEPTH) + 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [DATA_OUT_W-1:0]  ast_data_i;
  logic                   ast_startofpacket_i, ast_endofpacket_i, ast_valid_i;
  logic [EMPTY_OUT_W-1:0] ast_empty_i;
  logic [CHANNEL_W-1:0]   ast_channel_i;
  logic                   ast_ready_o;
  logic [DATA_OUT_W-1:0]  ast_data_o;
  logic                   ast_startofpacket_o, ast_endofpacket_o, ast_valid_o;
  logic [EMPTY_OUT_W-1:0] ast_empty_o;
  logic [CHANNEL_W-1:0]   ast_channel_o;
  logic                   ast_ready_i;
`ifdef AST_SF_LEVEL_EN
  logic [CW-1:0]          usedw_o, pkt_cnt_o;
`endif

  always #5 clk = ~clk;

  ast_store_forward_fifo dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .ast_data_i          (ast_data_i),
    .ast_startofpacket_i (ast_startofpacket_i),
    .ast_endofpacket_i   (ast_endofpacket_i),
    .ast_valid_i         (ast_valid_i),
    .ast_empty_i         (ast_empty_i),
    .ast_channel_i       (ast_channel_i),
    .ast_ready_o         (ast_ready_o),
    .ast_data_o          (ast_data_o),
    .ast_startofpacket_o (ast_startofpacket_o),
    .ast_endofpacket_o   (ast_endofpacket_o),
    .ast_valid_o         (ast_valid_o),
    .ast_empty_o         (ast_empty_o),
    .ast_channel_o       (ast_channel_o),
    .ast_ready_i         (ast_ready_i)
`ifdef AST_SF_LEVEL_EN
    ,
    .usedw_o             (usedw_o),
    .pkt_cnt_o           (pkt_cnt_o)
`endif
  );

  sf_word_t sb[$];
  int       n_cmp = 0;
  int       n_bad = 0;
  int       cyc = 0;
  int       eop_cyc = 0;
  int       popped = 0;
  int       p0;
  logic     allow_gaps = 1'b0;
  logic     in_pkt = 1'b0;
  logic     saw_full = 1'b0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, update scoreboard after it.
  task automatic step();
    logic     in_acc, out_acc;
    sf_word_t iw, ow, ew;
    in_acc  = ast_valid_i && ast_ready_o;
    out_acc = ast_valid_o && ast_ready_i;
    iw = {ast_data_i, ast_empty_i, ast_channel_i, ast_startofpacket_i, ast_endofpacket_i};
    ow = {ast_data_o, ast_empty_o, ast_channel_o, ast_startofpacket_o, ast_endofpacket_o};
    if (in_pkt && !allow_gaps) chk("no_gap", ast_valid_o, 1);
    @(posedge clk);
    #1;
    cyc++;
    if (in_acc) begin
      sb.push_back(iw);
      if (iw.eop) eop_cyc = cyc;
    end
    if (out_acc) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        ew = sb.pop_front();
        chk("word", ow, ew);
        popped++;
        if (ow.sop) in_pkt = 1'b1;
        if (ow.eop) in_pkt = 1'b0;
      end
    end
  endtask

  task automatic send_pkt(input int len, input logic [9:0] ch, input logic [3:0] emp,
                          input int gap_max, input logic with_eop);
    for (int i = 0; i < len; i++) begin
      int   g;
      int   w;
      logic acc;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      ast_valid_i = 1'b0;
      repeat (g) step();
      ast_valid_i         = 1'b1;
      ast_data_i          = {$urandom, $urandom, $urandom, $urandom};
      ast_startofpacket_i = (i == 0);
      ast_endofpacket_i   = (i == len - 1) && with_eop;
      ast_empty_i         = ast_endofpacket_i ? emp : 4'($urandom);
      ast_channel_i       = ch;
      w = 0;
      do begin
        acc = ast_ready_o;
        if (!acc) saw_full = 1'b1;
        step();
        w++;
      end while (!acc && w < 200);
      chk("send_accepted", acc, 1);
    end
    ast_valid_i         = 1'b0;
    ast_startofpacket_i = 1'b0;
    ast_endofpacket_i   = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || ast_valid_o) && w < 300) begin
      step();
      w++;
    end
    chk("drain_done", (sb.size() == 0) && !ast_valid_o, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n = 1'b0;
    ast_valid_i = 1'b0; ast_startofpacket_i = 1'b0; ast_endofpacket_i = 1'b0;
    ast_data_i = '0; ast_empty_i = '0; ast_channel_i = '0;
    ast_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ast_ready_o, 0);
    chk("rst_valid", ast_valid_o, 0);
    chk("rst_sop", ast_startofpacket_o, 0);
    chk("rst_eop", ast_endofpacket_o, 0);
    chk("rst_data", ast_data_o, 0);
    chk("rst_empty", ast_empty_o, 0);
    chk("rst_channel", ast_channel_o, 0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", ast_ready_o, 1);
`ifdef AST_SF_LEVEL_EN
    chk("rst_usedw", usedw_o, 0);
    chk("rst_pkt_cnt", pkt_cnt_o, 0);
`endif

    // single 3-word packet, latency from EOP accept to first valid word
    p0 = popped;
    send_pkt(3, 10'd5, 4'd4, 0, 1'b1);
    w = 0;
    while (!ast_valid_o && w < 20) begin step(); w++; end
    chk("latency", cyc - eop_cyc, 2);
    drain();
    chk("t1_count", popped - p0, 3);

    // five packets with random input gaps
    p0 = popped;
    w = 0;
    for (int k = 0; k < 5; k++) begin
      int len;
      len = int'($urandom_range(10, 1));
      w += len;
      send_pkt(len, 10'($urandom), 4'($urandom), 10, 1'b1);
    end
    drain();
    chk("t2_count", popped - p0, w);

    // fill with 16 one-word packets while downstream stalls
    ast_ready_i = 1'b0;
    for (int k = 0; k < 16; k++) send_pkt(1, 10'(k), 4'(k), 0, 1'b1);
    chk("full_ready_low", ast_ready_o, 0);
`ifdef AST_SF_LEVEL_EN
    chk("full_usedw", usedw_o, 16);
    chk("full_pkt_cnt", pkt_cnt_o, 16);
`endif
    p0 = popped;
    ast_ready_i = 1'b1;
    step();
    chk("ready_back", ast_ready_o, 1);
    drain();
    chk("t3_count", popped - p0, 16);

    // oversize packet escapes via cut-through
    allow_gaps = 1'b1;
    saw_full = 1'b0;
    p0 = popped;
    send_pkt(20, 10'd7, 4'd2, 0, 1'b1);
    chk("cut_full_seen", saw_full, 1);
    drain();
    chk("t4_count", popped - p0, 20);
    allow_gaps = 1'b0;

    // EOP write and EOP read on the same edge
    p0 = popped;
    ast_ready_i = 1'b0;
    send_pkt(1, 10'd1, 4'd0, 0, 1'b1);
    w = 0;
    while (!ast_valid_o && w < 20) begin step(); w++; end
    chk("t5_head_valid", ast_valid_o, 1);
`ifdef AST_SF_LEVEL_EN
    chk("t5_pkt_before", pkt_cnt_o, 1);
`endif
    ast_ready_i = 1'b1;
    send_pkt(1, 10'd2, 4'd3, 0, 1'b1);
`ifdef AST_SF_LEVEL_EN
    chk("t5_pkt_after", pkt_cnt_o, 1);
    chk("t5_usedw_after", usedw_o, 1);
`endif
    drain();
    chk("t5_count", popped - p0, 2);

    // reset with a partial packet stored, then a fresh packet
    send_pkt(6, 10'd3, 4'd0, 0, 1'b0);
`ifdef AST_SF_LEVEL_EN
    chk("t6_usedw", usedw_o, 6);
`endif
    chk("t6_no_output", ast_valid_o, 0);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_valid", ast_valid_o, 0);
    chk("t6_rst_ready", ast_ready_o, 0);
    sb.delete();
    in_pkt = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("t6_ready", ast_ready_o, 1);
    p0 = popped;
    send_pkt(2, 10'd9, 4'd1, 0, 1'b1);
    drain();
    chk("t6_count", popped - p0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ast_store_forward_fifo.md
# ast_store_forward_fifo

Store-and-forward packet FIFO on the 128-bit Avalon-ST output of the 64→128 width converter. It accepts converter output words and holds them until a whole packet (endofpacket word) is stored, then streams that packet out back-to-back. Downstream consumers therefore never see intra-packet valid gaps. An oversize-packet escape keeps the block deadlock-free.

## Interface
- DATA_W, 128, data width (converter output width)
- EMPTY_W, 4, empty field width, $clog2(DATA_W/8)
- CHANNEL_W, 10, channel width
- DEPTH, 16, storage depth in words, power of two ≥ 4

- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- ast_data_i  in  DATA_W  sink data
- ast_startofpacket_i  in  1  sink SOP
- ast_endofpacket_i  in  1  sink EOP
- ast_valid_i  in  1  sink valid
- ast_empty_i  in  EMPTY_W  sink empty bytes, meaningful on EOP only
- ast_channel_i  in  CHANNEL_W  sink channel
- ast_ready_o  out  1  sink ready
- ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_valid_o, ast_empty_o, ast_channel_o  out  as sink  source side
- ast_ready_i  in  1  source ready

## Operation
- Word stored = {data, empty, channel, sop, eop}, width DATA_W+EMPTY_W+CHANNEL_W+2.
- Write on ast_valid_i & ast_ready_o. Read on ast_valid_o & ast_ready_i.
- ast_ready_o = !full. Full/empty come from registered word count `used` (0..DEPTH).
- pkt_cnt counts complete packets stored: +1 on EOP write, −1 on EOP read, unchanged when both occur in one cycle.
- Output release: output enabled when pkt_cnt ≠ 0 or cut_thru = 1.
- cut_thru: set when used == DEPTH and pkt_cnt == 0, i.e. the head packet exceeds DEPTH. Cleared on the cycle the EOP word is read. While set, the packet streams as data arrives and may contain valid gaps.
- Data passes through unchanged, including empty and channel. The block does not check protocol; SOP/EOP framing is trusted.
- Simultaneous read and write when full: allowed only if the read occurs, since ready is based on the registered full flag. Ready therefore stays 0 on that cycle, and the write takes place next cycle.
- Pointers wrap modulo DEPTH. `used` uses $clog2(DEPTH)+1 bits.

## Timing
- Reset (rst_n_i low, async): pointers, used, pkt_cnt, cut_thru = 0. ast_valid_o, ast_startofpacket_o, ast_endofpacket_o = 0. ast_data_o, ast_empty_o, ast_channel_o = 0. ast_ready_o = 0 while in reset and 1 from the first clock after release.
- Reset mid-packet discards all contents. No partial packet appears after reset.
- Latency: EOP accepted at edge N → pkt_cnt updates at N+1 → first word valid on the output at N+2. Output is a registered stage fed by a synchronous-read memory.
- Once a packet starts, ast_valid_o stays high on every cycle until its EOP is read, except in cut-through mode.
- Throughput: 1 word/cycle in and out simultaneously.
- Output holds stable while ast_valid_o & !ast_ready_i.

## Configuration
- AST_SF_LEVEL_EN defined:
  - adds output ports usedw_o ($clog2(DEPTH)+1 bits, equals `used`) and pkt_cnt_o ($clog2(DEPTH)+1 bits).
  - both outputs are registered and reset to 0.
- AST_SF_LEVEL_EN undefined: the ports are absent and functionality is otherwise identical.

## Structure
- Shared package holds DATA_OUT_W, CHANNEL_W, EMPTY_OUT_W, the stored-word packed struct typedef and the DEPTH default. The bench and RTL use the same package.
- One sub-module, ast_sf_ram: simple dual-port RAM with registered read and no reset on the array. Control (pointers, counters, cut_thru, output stage) stays in the top.

## Test plan
- Single 3-word packet on channel 5, empty 4, ast_ready_i = 1 → nothing appears on the output until 2 cycles after EOP is accepted. Then 3 contiguous valid words, SOP on word 0, EOP+empty 4+channel 5 on word 2.
- Input with random 0–10 cycle valid gaps, 5 packets of length 1–10 → every output packet is gap-free and data matches byte-for-byte in order.
- ast_ready_i = 0 while 16 one-word packets are written → ast_ready_o drops after the 16th word. Releasing ready drains all 16, and ready returns 1 cycle after the first read.
- 20-word packet with DEPTH 16 → cut_thru asserts when used reaches 16, output starts, all 20 words delivered, no deadlock.
- Simultaneous EOP write and EOP read → pkt_cnt unchanged, with AST_SF_LEVEL_EN checked via pkt_cnt_o.
- rst_n_i asserted mid-packet with 6 words stored → ast_valid_o = 0 immediately. A following fresh 2-word packet is delivered alone.
